// File: rtl/stream_pkg.sv
// Shared encodings for the stream muxing blocks.
// No logic; latency and backpressure are defined by the modules that import it.
package stream_pkg;

    localparam logic MODE_SEL = 1'b0;
    localparam logic MODE_RR  = 1'b1;

    typedef enum logic {
        OUT_EMPTY = 1'b0,
        OUT_FULL  = 1'b1
    } out_state_e;

endpackage

// File: rtl/stream_mux_rr_arbiter.sv
// Round-robin request picker: first set req bit searching ptr, ptr+1, ... mod NCH.
// Purely combinational, zero latency; it has no handshake, so it applies no backpressure.
module rr_arbiter #(
    parameter  int NCH  = 4,
    localparam int SELW = $clog2(NCH)
) (
    input  logic [NCH-1:0]  req,
    input  logic [SELW-1:0] ptr,
    output logic [NCH-1:0]  gnt_oh,
    output logic [SELW-1:0] gnt_idx,
    output logic            any
);

    logic [SELW:0]   sum;
    logic [SELW-1:0] idx;

    always_comb begin
        gnt_oh  = '0;
        gnt_idx = '0;
        any     = 1'b0;
        sum     = '0;
        idx     = '0;
        for (int k = 0; k < NCH; k++) begin
            // One extra bit keeps ptr+k from overflowing before the explicit wrap.
            sum = {1'b0, ptr} + (SELW+1)'(k);
            if (sum >= (SELW+1)'(NCH)) begin
                sum = sum - (SELW+1)'(NCH);
            end
            idx = sum[SELW-1:0];
            if (!any && req[idx]) begin
                any         = 1'b1;
                gnt_idx     = idx;
                gnt_oh[idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/stream_mux_rr.sv
// N-channel valid/ready stream mux, fixed select or round-robin, one registered output stage.
// Latency 1 cycle; in_ready is 0 for all channels while the output is full and out_ready is low.
module stream_mux_rr
    import stream_pkg::*;
#(
    parameter  int WIDTH = 8,
    parameter  int NCH   = 4,
    localparam int SELW  = $clog2(NCH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 mode,
    input  logic [SELW-1:0]      sel,
    input  logic [NCH*WIDTH-1:0] in_data,
    input  logic [NCH-1:0]       in_valid,
    output logic [NCH-1:0]       in_ready,
    output logic [WIDTH-1:0]     out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [SELW-1:0]      out_ch
);

    out_state_e       state_q, state_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic [SELW-1:0]  out_ch_q, out_ch_d;
    logic [SELW-1:0]  ptr_q, ptr_d;

    logic [NCH-1:0]   rr_oh;
    logic [SELW-1:0]  rr_idx;
    logic             rr_any;

    logic             load_en;
    logic             gnt_any;
    logic [SELW-1:0]  gnt_idx;
    logic [NCH-1:0]   gnt_oh;
    logic             xfer;

    rr_arbiter #(.NCH(NCH)) u_arb (
        .req     (in_valid),
        .ptr     (ptr_q),
        .gnt_oh  (rr_oh),
        .gnt_idx (rr_idx),
        .any     (rr_any)
    );

    // Fixed mode never looks at in_valid, so in_ready stays free of a valid->ready path.
    always_comb begin
        load_en = (state_q == OUT_EMPTY) || out_ready;
        gnt_any = 1'b0;
        gnt_idx = '0;
        gnt_oh  = '0;
        if (mode == MODE_RR) begin
            gnt_any = rr_any;
            gnt_idx = rr_idx;
            gnt_oh  = rr_oh;
        end else begin
            gnt_any = 32'(sel) < 32'(NCH);
            gnt_idx = sel;
            gnt_oh  = gnt_any ? (NCH'(1'b1) << sel) : '0;
        end
        in_ready = load_en ? gnt_oh : '0;
        xfer     = |(in_valid & in_ready);
    end

    always_comb begin
        state_d = state_q;
        if (xfer) begin
            state_d = OUT_FULL;
        end else if ((state_q == OUT_FULL) && out_ready) begin
            state_d = OUT_EMPTY;
        end
    end

    always_comb begin
        out_data_d = out_data_q;
        out_ch_d   = out_ch_q;
        ptr_d      = ptr_q;
        if (xfer) begin
            out_ch_d = gnt_idx;
            for (int c = 0; c < NCH; c++) begin
                if (gnt_idx == SELW'(c)) begin
                    out_data_d = in_data[c*WIDTH +: WIDTH];
                end
            end
            if (mode == MODE_RR) begin
                ptr_d = (32'(gnt_idx) == 32'(NCH - 1)) ? '0 : gnt_idx + 1'b1;
            end
        end
    end

    always_comb begin
        out_valid = (state_q == OUT_FULL);
        out_data  = out_data_q;
        out_ch    = out_ch_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= OUT_EMPTY;
            out_data_q <= '0;
            out_ch_q   <= '0;
            ptr_q      <= '0;
        end else begin
            state_q    <= state_d;
            out_data_q <= out_data_d;
            out_ch_q   <= out_ch_d;
            ptr_q      <= ptr_d;
        end
    end

endmodule

// File: tb/tb_stream_mux_rr.sv
// Bench for stream_mux_rr: a 4-channel and a 3-channel instance run side by side against a reference model.
module tb_stream_mux_rr;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        mode;
    logic        out_ready;

    logic [1:0]  a_sel;
    logic [31:0] a_in_data;
    logic [3:0]  a_in_valid, a_in_ready;
    logic [7:0]  a_out_data;
    logic        a_out_valid;
    logic [1:0]  a_out_ch;

    logic [1:0]  b_sel;
    logic [23:0] b_in_data;
    logic [2:0]  b_in_valid, b_in_ready;
    logic [7:0]  b_out_data;
    logic        b_out_valid;
    logic [1:0]  b_out_ch;

    stream_mux_rr #(.WIDTH(8), .NCH(4)) dut_a (
        .clk(clk), .rst_n(rst_n), .mode(mode), .sel(a_sel),
        .in_data(a_in_data), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .out_data(a_out_data), .out_valid(a_out_valid), .out_ready(out_ready),
        .out_ch(a_out_ch)
    );

    stream_mux_rr #(.WIDTH(8), .NCH(3)) dut_b (
        .clk(clk), .rst_n(rst_n), .mode(mode), .sel(b_sel),
        .in_data(b_in_data), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .out_data(b_out_data), .out_valid(b_out_valid), .out_ready(out_ready),
        .out_ch(b_out_ch)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference model: index 0 is the 4-channel instance, index 1 the 3-channel one.
    int nch[2] = '{4, 3};
    int m_full[2];
    int m_data[2];
    int m_ch[2];
    int m_ptr[2];

    function automatic int valid_of(int d);
        return (d == 0) ? int'(a_in_valid) : int'(b_in_valid);
    endfunction

    function automatic int sel_of(int d);
        return (d == 0) ? int'(a_sel) : int'(b_sel);
    endfunction

    function automatic int slice_of(int d, int c);
        return (d == 0) ? int'(a_in_data[c*8 +: 8]) : int'(b_in_data[c*8 +: 8]);
    endfunction

    function automatic int grant_of(int d);
        if (!mode) begin
            return (sel_of(d) < nch[d]) ? sel_of(d) : -1;
        end
        for (int k = 0; k < nch[d]; k++) begin
            int c = (m_ptr[d] + k) % nch[d];
            if (((valid_of(d) >> c) & 1) != 0) return c;
        end
        return -1;
    endfunction

    function automatic int ready_of(int d);
        int g = grant_of(d);
        if (g < 0) return 0;
        if (m_full[d] != 0 && !out_ready) return 0;
        return 1 << g;
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_full[d] = 0;
            m_data[d] = 0;
            m_ch[d]   = 0;
            m_ptr[d]  = 0;
        end
    endtask

    task automatic check_outputs();
        check_eq("a_out_valid", a_out_valid, m_full[0]);
        check_eq("a_out_data",  a_out_data,  m_data[0]);
        check_eq("a_out_ch",    a_out_ch,    m_ch[0]);
        check_eq("b_out_valid", b_out_valid, m_full[1]);
        check_eq("b_out_data",  b_out_data,  m_data[1]);
        check_eq("b_out_ch",    b_out_ch,    m_ch[1]);
    endtask

    // Inputs are already driven; check ready mid-cycle, take the edge, check outputs just after it.
    task automatic cycle();
        int g[2];
        int xf[2];
        int dat[2];
        int pop[2];
        logic md;
        #1;
        check_eq("a_in_ready", a_in_ready, ready_of(0));
        check_eq("b_in_ready", b_in_ready, ready_of(1));
        md = mode;
        for (int d = 0; d < 2; d++) begin
            g[d]   = grant_of(d);
            xf[d]  = (ready_of(d) != 0 && ((valid_of(d) >> g[d]) & 1) != 0) ? 1 : 0;
            dat[d] = (xf[d] != 0) ? slice_of(d, g[d]) : 0;
            pop[d] = (m_full[d] != 0 && out_ready) ? 1 : 0;
        end
        @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            if (xf[d] != 0) begin
                m_full[d] = 1;
                m_data[d] = dat[d];
                m_ch[d]   = g[d];
                if (md) m_ptr[d] = (g[d] + 1) % nch[d];
            end else if (pop[d] != 0) begin
                m_full[d] = 0;
            end
        end
        check_outputs();
    endtask

    // Called just after a clock edge; asserts reset between edges and releases it before the next one.
    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        check_eq("rst_a_valid", a_out_valid, 0);
        check_eq("rst_a_data",  a_out_data,  0);
        check_eq("rst_a_ch",    a_out_ch,    0);
        check_eq("rst_b_valid", b_out_valid, 0);
        check_eq("rst_b_data",  b_out_data,  0);
        #2;
        rst_n = 1'b1;
        model_reset();
    endtask

    initial begin
        rst_n      = 1'b0;
        mode       = 1'b0;
        out_ready  = 1'b0;
        a_sel      = '0;
        a_in_data  = '0;
        a_in_valid = '0;
        b_sel      = '0;
        b_in_data  = '0;
        b_in_valid = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        do_reset();

        // Fixed select, single beat through.
        mode = 1'b0; out_ready = 1'b1;
        a_sel = 2'd2; a_in_data = 32'h00A5_0000; a_in_valid = 4'b0100;
        b_sel = 2'd2; b_in_data = 24'hC3_0000;   b_in_valid = 3'b100;
        #1;
        check_eq("t1_a_in_ready", a_in_ready, 4'b0100);
        cycle();
        check_eq("t1_data",  a_out_data,  8'hA5);
        check_eq("t1_ch",    a_out_ch,    2'd2);
        check_eq("t1_valid", a_out_valid, 1'b1);

        // Stall holds the beat, then pop and reload in one edge.
        a_sel = 2'd1; a_in_data = 32'h0000_3C00; a_in_valid = 4'b0010;
        cycle();
        out_ready = 1'b0;
        a_in_data = 32'h0000_5A00;
        for (int i = 0; i < 3; i++) begin
            cycle();
            check_eq("t2_hold_data", a_out_data, 8'h3C);
        end
        out_ready = 1'b1;
        cycle();
        check_eq("t2_reload_data",  a_out_data,  8'h5A);
        check_eq("t2_reload_valid", a_out_valid, 1'b1);

        // Round-robin fairness with every channel requesting.
        do_reset();
        mode = 1'b1; out_ready = 1'b1;
        a_in_data = 32'h1312_1110; a_in_valid = 4'b1111;
        b_in_data = 24'h22_2120;   b_in_valid = 3'b111;
        for (int i = 0; i < 8; i++) begin
            cycle();
            check_eq("t3_rr_ch",   a_out_ch,   i % 4);
            check_eq("t3_rr_data", a_out_data, 8'h10 + i % 4);
        end

        // Pointer moves past the grant; the 3-channel instance wraps from 2 to 0.
        a_in_valid = 4'b0100; b_in_valid = 3'b100;
        cycle();
        a_in_valid = 4'b0010; b_in_valid = 3'b111;
        cycle();
        check_eq("t4_a_ch1",  a_out_ch, 2'd1);
        check_eq("t4_b_wrap", b_out_ch, 2'd0);
        a_in_valid = 4'b1111;
        cycle();
        check_eq("t4_a_after_ptr2", a_out_ch, 2'd2);

        // Out-of-range select on the 3-channel instance grants nothing.
        mode = 1'b0; b_sel = 2'd3;
        #1;
        check_eq("t5_b_sel_oob", b_in_ready, 3'b000);
        cycle();

        // Round-robin with no requests drains, pointer keeps its value.
        mode = 1'b1; a_in_valid = '0; b_in_valid = '0;
        cycle();
        check_eq("t6_drain", a_out_valid, 1'b0);
        cycle();
        a_in_valid = 4'b1111;
        cycle();
        check_eq("t6_ptr_kept", a_out_ch, 2'd3);

        // Asynchronous reset while a beat is held; pointer restarts at 0.
        out_ready = 1'b0;
        cycle();
        do_reset();
        out_ready = 1'b1;
        cycle();
        check_eq("t7_ptr_reset", a_out_ch, 2'd0);

        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 15) == 0) mode = 1'($urandom);
            a_sel      = 2'($urandom_range(0, 3));
            b_sel      = 2'($urandom_range(0, 3));
            a_in_data  = $urandom;
            b_in_data  = 24'($urandom);
            a_in_valid = 4'($urandom);
            b_in_valid = 3'($urandom);
            out_ready  = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 99) == 0) do_reset();
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/stream_mux_rr.md
# stream_mux_rr

Parametrised N-channel stream multiplexer with valid/ready handshakes on every input and on the output, and a single registered output stage. The channel is chosen either by an external select (fixed mode) or by a fair round-robin arbiter. It succeeds the combinational 4-to-1 mux: it adds width, channel count, back-pressure and arbitration. It sits between multiple producer streams and one consumer in the datapath.

## Interface
- `WIDTH`, 8, data bits per channel.
- `NCH`, 4, number of input channels (>= 2).
- `SELW`, `$clog2(NCH)`, select/channel-id width (derived; never overridden).
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `mode`  in  1  0 = fixed select, 1 = round-robin.
- `sel`  in  SELW  channel index used when `mode`=0.
- `in_data`  in  NCH*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
- `in_valid`  in  NCH  per-channel valid.
- `in_ready`  out  NCH  per-channel ready; at most one bit high per cycle.
- `out_data`  out  WIDTH  registered output beat.
- `out_valid`  out  1  output register holds a beat.
- `out_ready`  in  1  consumer accepts the beat.
- `out_ch`  out  SELW  index of the channel that produced `out_data`.

## Operation
- The output register has two states: EMPTY (`out_valid`=0) and FULL (`out_valid`=1).
- `load_en` = !out_valid || out_ready.
- Grant, computed combinationally each cycle:
  - `mode`=0: `gnt` = `sel`.
  - `mode`=1: `gnt` = the first channel with `in_valid` set, searching `ptr`, `ptr`+1, … mod NCH.
- `in_ready[gnt]` = `load_en`; all other `in_ready` bits are 0.
  - In mode 1 with no valid channel, all `in_ready` bits are 0.
- A transfer on channel i occurs when `in_valid[i]` && `in_ready[i]`. On that edge:
  - `out_data` <= the channel's slice.
  - `out_ch` <= i.
  - `out_valid` <= 1.
- Output pop (`out_valid` && `out_ready`) with no simultaneous transfer: `out_valid` <= 0; `out_data` and `out_ch` hold.
- Pop and transfer in the same cycle: the register reloads, `out_valid` stays 1, and no bubble is inserted.
- Round-robin pointer `ptr` (SELW bits):
  - On a mode-1 transfer, `ptr` <= (gnt+1) mod NCH. Handle wrap explicitly when NCH is not a power of 2.
  - `ptr` is unchanged otherwise, including during mode 0.
- `sel` >= NCH (non-power-of-2 NCH) is treated as no grant: all `in_ready` bits are 0.
- Changing `mode` or `sel` while FULL does not alter the held beat. The new setting applies from the next grant.
- `in_ready` must not depend combinationally on `in_valid` of the same channel in mode 0. In mode 1 it depends on `in_valid` through arbitration only.

## Timing
- Reset values: `out_valid`=0, `out_data`=0, `out_ch`=0, `ptr`=0. `in_ready` then follows the combinational rule with `out_valid`=0.
- Reset assertion mid-operation clears the held beat immediately and asynchronously. It is not delivered.
- Latency: an input accepted at edge k appears on `out_data`/`out_valid` after edge k.
- Throughput: 1 beat/cycle when `out_ready` is held high.
- Stall: while FULL and `out_ready`=0, `out_data`/`out_ch` are stable and all `in_ready` bits are 0.
- Fairness (mode 1, all channels valid, `out_ready`=1): grants are issued 0,1,…,NCH-1,0,… with no channel starved longer than NCH-1 transfers.

## Structure
- A shared package `stream_pkg` holds the mode encodings (`MODE_SEL`=1'b0, `MODE_RR`=1'b1).
- One sub-module is natural: `rr_arbiter` (parameter NCH; inputs `req`, `ptr`; outputs one-hot `gnt_oh`, `gnt_idx`, `any`). The top level contains the mux, the output register and the pointer update.

## Test plan
- Reset, then `mode`=0, `sel`=2, `in_data` ch2=0xA5, `in_valid`=4'b0100, `out_ready`=1 -> `in_ready`=4'b0100; next cycle `out_data`=0xA5, `out_ch`=2, `out_valid`=1.
- `mode`=0, `sel`=1, ch1 valid, `out_ready`=0 for 3 cycles -> first beat held stable; `in_ready`=0 after the first load; `out_ready`=1 pops and reloads the same cycle, with no bubble.
- `mode`=1, all 4 channels valid with data 0x10..0x13, `out_ready`=1 for 8 cycles -> `out_ch` sequence 0,1,2,3,0,1,2,3 and `out_data` matching.
- `mode`=1, `ptr`=3, only ch1 valid -> grant ch1, `ptr` becomes 2; NCH=3 build: grant ch2 -> `ptr` wraps to 0.
- Assert `rst_n`=0 asynchronously mid-stream while FULL -> `out_valid` drops to 0 before the next edge, `ptr`=0, `out_data`=0.
- `mode`=1, no `in_valid` bits set -> `in_ready`=0, `out_valid` falls after the pending beat pops, `ptr` unchanged.
